serial_subtractor: RTL and testbench

//   Bit-serial 6-bit two's-complement subtractor: z = a - b, one bit per clock, LSB first.

---
 rtl/serial_subtractor.sv | 98 +++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor z = a - b, LSB first, one bit per clock.
// Start/busy/done handshake; z and the flags hold until the next operation completes.
module serial_subtractor #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             borrowOut,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [WIDTH-2:0] sh_z;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb, b_msb;

    logic             diff_bit, br_next, last, load;
    logic [WIDTH-1:0] z_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        diff_bit   = sh_a[0] ^ sh_b[0] ^ br;
        br_next    = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);
        // The partial result keeps only the upper WIDTH-1 bits; the new bit completes it.
        z_next     = {diff_bit, sh_z};
        last       = (cnt == CW'(WIDTH - 1));
        busy       = (state == RUN);
        done       = (state == DONE);
        case (state)
            IDLE: if (start) begin
                load       = 1'b1;
                state_next = RUN;
            end
            RUN:  if (last) state_next = DONE;
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_a      <= '0;
            sh_b      <= '0;
            sh_z      <= '0;
            cnt       <= '0;
            br        <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            z         <= '0;
            borrowOut <= 1'b0;
            overflow  <= 1'b0;
        end else if (load) begin
            sh_a  <= a;
            sh_b  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            sh_z <= z_next[WIDTH-1:1];
            br   <= br_next;
            cnt  <= cnt + CW'(1);
            if (last) begin
                z         <= z_next;
                borrowOut <= br_next;
                overflow  <= (a_msb ^ b_msb) & (diff_bit ^ a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: results, flags, latency, handshake and reset abort.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [5:0] a, b;
    logic       busy, done;
    logic [5:0] z;
    logic       borrowOut, overflow;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(6)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .z(z), .borrowOut(borrowOut), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, z, borrowOut, overflow} !== 10'b0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b z=%b bo=%b ov=%b want all 0",
                     busy, done, z, borrowOut, overflow);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [5:0] va [5] = '{6'd5, 6'd3, 6'b100000, 6'b011111, 6'd9};
        logic [5:0] vb [5] = '{6'd3, 6'd5, 6'd1,      6'b111111, 6'd9};
        logic [5:0] vz [5] = '{6'b000010, 6'b111110, 6'b011111, 6'b100000, 6'b000000};
        logic       vbo[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       vov[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            int lat = 0, busy_cnt = 0;
            bit seen = 0;
            a = va[i]; b = vb[i]; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; a = ~va[i]; b = ~vb[i];
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                lat++;
                if (done) seen = 1;
                else if (busy) busy_cnt++;
            end
            checks++;
            if (!seen || lat != 7) begin
                failures++;
                $display("FAIL vec%0d_latency got seen=%0d lat=%0d want lat=7", i, seen, lat);
            end
            checks++;
            if (busy_cnt != 6) begin
                failures++;
                $display("FAIL vec%0d_busy_cycles got %0d want 6", i, busy_cnt);
            end
            checks++;
            if ({z, borrowOut, overflow} !== {vz[i], vbo[i], vov[i]}) begin
                failures++;
                $display("FAIL vec%0d_result got z=%b bo=%b ov=%b want z=%b bo=%b ov=%b",
                         i, z, borrowOut, overflow, vz[i], vbo[i], vov[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || z !== vz[i]) begin
                failures++;
                $display("FAIL vec%0d_idle_hold got done=%b busy=%b z=%b want done=0 busy=0 z=%b",
                         i, done, busy, z, vz[i]);
            end
        end
    endtask

    task automatic test_start_during_run();
        int lat = 0, first_lat = 0, dones = 0;
        a = 6'd10; b = 6'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                dones++;
                if (first_lat == 0) first_lat = lat;
            end
            if (c == 1) begin a = 6'd1; b = 6'd20; start = 1'b1; end
            else start = 1'b0;
        end
        checks++;
        if (dones != 1 || first_lat != 7) begin
            failures++;
            $display("FAIL midrun_start_done got dones=%0d lat=%0d want dones=1 lat=7", dones, first_lat);
        end
        checks++;
        if ({z, borrowOut, overflow} !== {6'd6, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midrun_start_result got z=%b bo=%b ov=%b want z=000110 bo=0 ov=0",
                     z, borrowOut, overflow);
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        bit seen = 0;
        a = 6'd12; b = 6'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        checks++;
        if (!seen || z !== 6'd11) begin
            failures++;
            $display("FAIL b2b_first got seen=%0d z=%b want seen=1 z=001011", seen, z);
        end
        a = 6'd7; b = 6'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = '0; b = '1;
        @(negedge clk);
        lat = 1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || z !== 6'd11) begin
            failures++;
            $display("FAIL b2b_no_idle got busy=%b done=%b z=%b want busy=1 done=0 z=001011",
                     busy, done, z);
        end
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1;
        end
        checks++;
        if (!seen || lat != 7 || {z, borrowOut, overflow} !== {6'd5, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_second got seen=%0d lat=%0d z=%b bo=%b ov=%b want lat=7 z=000101 bo=0 ov=0",
                     seen, lat, z, borrowOut, overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int dones = 0, lat = 0;
        bit seen = 0;
        a = 6'd20; b = 6'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, z, borrowOut, overflow} !== 10'b0) begin
            failures++;
            $display("FAIL reset_midrun_outputs got busy=%b done=%b z=%b bo=%b ov=%b want all 0",
                     busy, done, z, borrowOut, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_midrun_abort got dones=%0d busy=%b want dones=0 busy=0", dones, busy);
        end
        a = 6'd20; b = 6'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1;
        end
        checks++;
        if (!seen || lat != 7 || {z, borrowOut, overflow} !== {6'd17, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_fresh_op got seen=%0d lat=%0d z=%b bo=%b ov=%b want lat=7 z=010001 bo=0 ov=0",
                     seen, lat, z, borrowOut, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
